// File: rtl/sap_pkg.sv
// Shared definitions for the SAP control sequencer.
//   - opcode values carried in IR[7:4]
//   - T-state encodings T1..T5 (encoded as their step number)
//   - ALU operation codes
//   - bit positions within the internal control word
package sap_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_INC = 4'h9;
    localparam logic [3:0] OP_DCR = 4'hA;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } tstate_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_INC = 2'b10;
    localparam logic [1:0] ALU_DCR = 2'b11;

    localparam int CW_PC_OUT   = 0;
    localparam int CW_PC_INC   = 1;
    localparam int CW_JUMP     = 2;
    localparam int CW_MAR_IN   = 3;
    localparam int CW_RAM_OUT  = 4;
    localparam int CW_RAM_IN   = 5;
    localparam int CW_IR_IN    = 6;
    localparam int CW_IR_OUT   = 7;
    localparam int CW_ACC_IN   = 8;
    localparam int CW_ACC_OUT  = 9;
    localparam int CW_B_IN     = 10;
    localparam int CW_OUT_IN   = 11;
    localparam int CW_ALU_OUT  = 12;
    localparam int CW_FLAGS_LD = 13;
    localparam int CW_W        = 14;

endpackage

// File: rtl/sap_ctrl_decode.sv
// Pure combinational microcode decode: (t_state, opcode, flags_q) -> control word.
// Ports:
//   t_state   in  3         current step (T1..T5)
//   opcode    in  4         IR[7:4]
//   flags_q   in  2         latched {Zero,Carry}, used only by JC/JZ
//   cw        out CW_W      control word, bit positions from sap_pkg
//   alu_op    out 2         ALU operation, ADD when not in an ALU step
//   last_step out 1         this step ends the instruction
module sap_ctrl_decode
    import sap_pkg::*;
(
    input  logic [2:0]      t_state,
    input  logic [3:0]      opcode,
    input  logic [1:0]      flags_q,
    output logic [CW_W-1:0] cw,
    output logic [1:0]      alu_op,
    output logic            last_step
);

    always_comb begin
        cw        = '0;
        alu_op    = ALU_ADD;
        last_step = 1'b0;
        case (t_state)
            T1: begin
                cw[CW_PC_OUT] = 1'b1;
                cw[CW_MAR_IN] = 1'b1;
            end
            T2: begin
                cw[CW_RAM_OUT] = 1'b1;
                cw[CW_IR_IN]   = 1'b1;
                cw[CW_PC_INC]  = 1'b1;
            end
            T3: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_MAR_IN] = 1'b1;
                    end
                    OP_LDI: begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_ACC_IN] = 1'b1;
                        last_step     = 1'b1;
                    end
                    OP_JMP: begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_JUMP]   = 1'b1;
                        last_step     = 1'b1;
                    end
                    OP_JC: begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_JUMP]   = flags_q[0];
                        last_step     = 1'b1;
                    end
                    OP_JZ: begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_JUMP]   = flags_q[1];
                        last_step     = 1'b1;
                    end
                    OP_INC, OP_DCR: begin
                        cw[CW_ALU_OUT]  = 1'b1;
                        cw[CW_ACC_IN]   = 1'b1;
                        cw[CW_FLAGS_LD] = 1'b1;
                        alu_op          = (opcode == OP_INC) ? ALU_INC : ALU_DCR;
                        last_step       = 1'b1;
                    end
                    OP_OUT: begin
                        cw[CW_ACC_OUT] = 1'b1;
                        cw[CW_OUT_IN]  = 1'b1;
                        last_step      = 1'b1;
                    end
                    // HLT never ends: the top parks in T3 with halted set
                    OP_HLT: last_step = 1'b0;
                    default: last_step = 1'b1;
                endcase
            end
            T4: begin
                case (opcode)
                    OP_LDA: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_ACC_IN]  = 1'b1;
                        last_step      = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_B_IN]    = 1'b1;
                    end
                    OP_STA: begin
                        cw[CW_ACC_OUT] = 1'b1;
                        cw[CW_RAM_IN]  = 1'b1;
                        last_step      = 1'b1;
                    end
                    default: last_step = 1'b1;
                endcase
            end
            T5: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    cw[CW_ALU_OUT]  = 1'b1;
                    cw[CW_ACC_IN]   = 1'b1;
                    cw[CW_FLAGS_LD] = 1'b1;
                    alu_op          = (opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
                end
                last_step = 1'b1;
            end
            // Unreachable encodings fall back to the start of fetch
            default: last_step = 1'b1;
        endcase
    end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP control unit: T-state counter, flag register and halt flag around the
// microcode decoder. Control outputs are combinational from the current state.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   en                    step enable; low freezes state and zeroes strobes
//   opcode, alu_flags     IR[7:4] and ALU {Zero,Carry}
//   pc_out..alu_out       control strobes
//   alu_op                ALU op, 00 when unused
//   flags_q, t_state      latched {Z,C}, current step 1..5
//   halted                HLT executed
//
// state | meaning
// T1    | fetch: PC -> MAR
// T2    | fetch: RAM -> IR, PC++
// T3    | execute step 1 (HLT parks here)
// T4    | execute step 2
// T5    | execute step 3 (ADD/SUB only)
module sap_control_sequencer
    import sap_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int FLAG_W   = 2
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FLAG_W-1:0]   alu_flags,
    output logic                pc_out,
    output logic                pc_inc,
    output logic                jump,
    output logic                mar_in,
    output logic                ram_out,
    output logic                ram_in,
    output logic                ir_in,
    output logic                ir_out,
    output logic                acc_in,
    output logic                acc_out,
    output logic                b_in,
    output logic                out_in,
    output logic                alu_out,
    output logic [1:0]          alu_op,
    output logic [FLAG_W-1:0]   flags_q,
    output logic [2:0]          t_state,
    output logic                halted
);

    tstate_e           state_q, state_d;
    logic [FLAG_W-1:0] flags_r, flags_d;
    logic              halted_q, halted_d;
    logic [CW_W-1:0]   cw_dec, cw;
    logic [1:0]        alu_op_dec;
    logic              last_step;
    logic              active;

    sap_ctrl_decode u_decode (
        .t_state   (state_q),
        .opcode    (opcode),
        .flags_q   (flags_r),
        .cw        (cw_dec),
        .alu_op    (alu_op_dec),
        .last_step (last_step)
    );

    // rst_n gates the strobes so nothing fires while reset is held
    assign active = en && !halted_q && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= T1;
            flags_r  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flags_r  <= flags_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        flags_d  = flags_r;
        halted_d = halted_q;
        cw       = '0;
        alu_op   = ALU_ADD;
        if (active) begin
            cw     = cw_dec;
            alu_op = alu_op_dec;
            if (state_q == T3 && opcode == OP_HLT) begin
                halted_d = 1'b1;
            end else if (last_step) begin
                state_d = T1;
            end else begin
                state_d = tstate_e'(state_q + 3'd1);
            end
            if (cw_dec[CW_FLAGS_LD]) begin
                flags_d = alu_flags;
            end
        end
    end

    assign pc_out  = cw[CW_PC_OUT];
    assign pc_inc  = cw[CW_PC_INC];
    assign jump    = cw[CW_JUMP];
    assign mar_in  = cw[CW_MAR_IN];
    assign ram_out = cw[CW_RAM_OUT];
    assign ram_in  = cw[CW_RAM_IN];
    assign ir_in   = cw[CW_IR_IN];
    assign ir_out  = cw[CW_IR_OUT];
    assign acc_in  = cw[CW_ACC_IN];
    assign acc_out = cw[CW_ACC_OUT];
    assign b_in    = cw[CW_B_IN];
    assign out_in  = cw[CW_OUT_IN];
    assign alu_out = cw[CW_ALU_OUT];
    assign flags_q = flags_r;
    assign t_state = state_q;
    assign halted  = halted_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
module tb_sap_control_sequencer;

    logic       clk, rst_n, en;
    logic [3:0] opcode;
    logic [1:0] alu_flags;
    logic       pc_out, pc_inc, jump, mar_in, ram_out, ram_in, ir_in, ir_out;
    logic       acc_in, acc_out, b_in, out_in, alu_out;
    logic [1:0] alu_op, flags_q;
    logic [2:0] t_state;
    logic       halted;

    sap_control_sequencer dut (
        .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .alu_flags(alu_flags),
        .pc_out(pc_out), .pc_inc(pc_inc), .jump(jump), .mar_in(mar_in),
        .ram_out(ram_out), .ram_in(ram_in), .ir_in(ir_in), .ir_out(ir_out),
        .acc_in(acc_in), .acc_out(acc_out), .b_in(b_in), .out_in(out_in),
        .alu_out(alu_out), .alu_op(alu_op), .flags_q(flags_q),
        .t_state(t_state), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe masks in bench order {pc_out,pc_inc,jump,mar_in,ram_out,ram_in,ir_in,ir_out,acc_in,acc_out,b_in,out_in,alu_out}
    localparam logic [12:0] M_PC_OUT  = 13'h1000;
    localparam logic [12:0] M_PC_INC  = 13'h0800;
    localparam logic [12:0] M_JUMP    = 13'h0400;
    localparam logic [12:0] M_MAR_IN  = 13'h0200;
    localparam logic [12:0] M_RAM_OUT = 13'h0100;
    localparam logic [12:0] M_RAM_IN  = 13'h0080;
    localparam logic [12:0] M_IR_IN   = 13'h0040;
    localparam logic [12:0] M_IR_OUT  = 13'h0020;
    localparam logic [12:0] M_ACC_IN  = 13'h0010;
    localparam logic [12:0] M_ACC_OUT = 13'h0008;
    localparam logic [12:0] M_B_IN    = 13'h0004;
    localparam logic [12:0] M_OUT_IN  = 13'h0002;
    localparam logic [12:0] M_ALU_OUT = 13'h0001;

    // Reference microprogram: per opcode, strobes per step, ALU op per step,
    // instruction length and the step whose end latches the flags (0 = none).
    logic [12:0] uprog   [0:15][0:5];
    logic [1:0]  uop_alu [0:15][0:5];
    int          len     [0:15];
    int          fl_step [0:15];

    int          m_t;
    logic [1:0]  m_flags;
    bit          m_halted;

    int          checks = 0;
    int          errors = 0;

    logic [12:0] s_cw;
    logic [1:0]  s_alu, s_flags;
    logic [2:0]  s_t;
    logic        s_halted;

    logic [3:0]  r_op;
    logic        r_en;
    int          guard;
    bit          moved;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_cycle(input logic e, input logic [3:0] op, input logic [1:0] fl);
        logic [12:0] exp_cw;
        logic [1:0]  exp_alu;
        bit          act;
        @(negedge clk);
        en = e;
        opcode = op;
        alu_flags = fl;
        #1;
        act = e && !m_halted;
        exp_cw = '0;
        exp_alu = '0;
        if (act) begin
            exp_cw = uprog[op][m_t];
            if (m_t == 3 && op == 4'h7 && m_flags[0]) exp_cw = exp_cw | M_JUMP;
            if (m_t == 3 && op == 4'h8 && m_flags[1]) exp_cw = exp_cw | M_JUMP;
            exp_alu = uop_alu[op][m_t];
        end
        s_cw = {pc_out, pc_inc, jump, mar_in, ram_out, ram_in, ir_in, ir_out,
                acc_in, acc_out, b_in, out_in, alu_out};
        s_alu = alu_op;
        s_t = t_state;
        s_flags = flags_q;
        s_halted = halted;
        chk("control_word", 32'(s_cw), 32'(exp_cw));
        chk("alu_op", 32'(s_alu), 32'(exp_alu));
        chk("t_state", 32'(s_t), 32'(m_t));
        chk("flags_q", 32'(s_flags), 32'(m_flags));
        chk("halted", 32'(s_halted), 32'(m_halted));
        chk("bus_onehot0", 32'($onehot0({pc_out, ram_out, ir_out, acc_out, alu_out})), 32'd1);
        @(posedge clk);
        if (act) begin
            if (op == 4'hF && m_t == 3) begin
                m_halted = 1'b1;
            end else begin
                if (fl_step[op] == m_t) m_flags = fl;
                if (m_t >= len[op]) m_t = 1;
                else m_t = m_t + 1;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b1;
        #1;
        chk("rst_t_state", 32'(t_state), 32'd1);
        chk("rst_flags_q", 32'(flags_q), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_strobes", 32'({pc_out, pc_inc, jump, mar_in, ram_out, ram_in, ir_in, ir_out,
                                acc_in, acc_out, b_in, out_in, alu_out, alu_op}), 32'd0);
        m_t = 1;
        m_flags = 2'b00;
        m_halted = 1'b0;
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        opcode = 4'h0;
        alu_flags = 2'b00;
        m_t = 1;
        m_flags = 2'b00;
        m_halted = 1'b0;

        for (int op = 0; op < 16; op++) begin
            for (int t = 0; t < 6; t++) begin
                uprog[op][t] = '0;
                uop_alu[op][t] = 2'b00;
            end
            uprog[op][1] = M_PC_OUT | M_MAR_IN;
            uprog[op][2] = M_RAM_OUT | M_IR_IN | M_PC_INC;
            len[op] = 3;
            fl_step[op] = 0;
        end
        len[1] = 4;  uprog[1][3] = M_IR_OUT | M_MAR_IN;  uprog[1][4] = M_RAM_OUT | M_ACC_IN;
        for (int op = 2; op <= 3; op++) begin
            len[op] = 5;
            uprog[op][3] = M_IR_OUT | M_MAR_IN;
            uprog[op][4] = M_RAM_OUT | M_B_IN;
            uprog[op][5] = M_ALU_OUT | M_ACC_IN;
            uop_alu[op][5] = 2'(op - 2);
            fl_step[op] = 5;
        end
        len[4] = 4;  uprog[4][3] = M_IR_OUT | M_MAR_IN;  uprog[4][4] = M_ACC_OUT | M_RAM_IN;
        uprog[5][3] = M_IR_OUT | M_ACC_IN;
        uprog[6][3] = M_IR_OUT | M_JUMP;
        uprog[7][3] = M_IR_OUT;
        uprog[8][3] = M_IR_OUT;
        uprog[9][3] = M_ALU_OUT | M_ACC_IN;   uop_alu[9][3] = 2'b10;   fl_step[9] = 3;
        uprog[10][3] = M_ALU_OUT | M_ACC_IN;  uop_alu[10][3] = 2'b11;  fl_step[10] = 3;
        uprog[14][3] = M_ACC_OUT | M_OUT_IN;

        apply_reset();

        // INC leaving flags at 11 so the following reset has something to clear
        step_cycle(1, 4'h9, 2'b00);
        step_cycle(1, 4'h9, 2'b00);
        step_cycle(1, 4'h9, 2'b11);
        chk("inc_alu_op", 32'(s_alu), 32'd2);

        // ADD interrupted by reset during T4
        step_cycle(1, 4'h2, 2'b11);
        step_cycle(1, 4'h2, 2'b11);
        step_cycle(1, 4'h2, 2'b11);
        chk("add_pre_rst_flags", 32'(s_flags), 32'd3);
        apply_reset();
        step_cycle(1, 4'h2, 2'b11);
        chk("rst_release_fetch", 32'(s_cw), 32'(M_PC_OUT | M_MAR_IN));

        // Full ADD: flags only follow alu_flags at T5
        step_cycle(1, 4'h2, 2'b11);
        step_cycle(1, 4'h2, 2'b11);
        step_cycle(1, 4'h2, 2'b11);
        step_cycle(1, 4'h2, 2'b01);
        chk("add_t5_cw", 32'(s_cw), 32'(M_ALU_OUT | M_ACC_IN));
        chk("add_t5_alu_op", 32'(s_alu), 32'd0);
        chk("add_t5_step", 32'(s_t), 32'd5);

        // JC then JZ with flags 01
        step_cycle(1, 4'h7, 2'b10);
        chk("add_flags_latched", 32'(s_flags), 32'd1);
        chk("add_back_to_t1", 32'(s_t), 32'd1);
        step_cycle(1, 4'h7, 2'b10);
        step_cycle(1, 4'h7, 2'b10);
        chk("jc_c1_jump", 32'(s_cw[10]), 32'd1);
        step_cycle(1, 4'h8, 2'b10);
        chk("jc_3cycles", 32'(s_t), 32'd1);
        step_cycle(1, 4'h8, 2'b10);
        step_cycle(1, 4'h8, 2'b10);
        chk("jz_z0_nojump", 32'(s_cw[10]), 32'd0);

        // DCR to zero, then JZ taken and JC not
        step_cycle(1, 4'hA, 2'b01);
        step_cycle(1, 4'hA, 2'b01);
        step_cycle(1, 4'hA, 2'b10);
        chk("dcr_alu_op", 32'(s_alu), 32'd3);
        step_cycle(1, 4'h8, 2'b01);
        chk("dcr_flags", 32'(s_flags), 32'd2);
        step_cycle(1, 4'h8, 2'b01);
        step_cycle(1, 4'h8, 2'b01);
        chk("jz_z1_jump", 32'(s_cw[10]), 32'd1);
        step_cycle(1, 4'h7, 2'b01);
        step_cycle(1, 4'h7, 2'b01);
        step_cycle(1, 4'h7, 2'b01);
        chk("jc_c0_nojump", 32'(s_cw[10]), 32'd0);

        // LDA stalled at T4
        step_cycle(1, 4'h1, 2'b11);
        chk("jz_3cycles", 32'(s_t), 32'd1);
        step_cycle(1, 4'h1, 2'b11);
        step_cycle(1, 4'h1, 2'b11);
        for (int i = 0; i < 3; i++) begin
            step_cycle(0, 4'h1, 2'b11);
            chk("stall_cw", 32'(s_cw), 32'd0);
            chk("stall_t4", 32'(s_t), 32'd4);
        end
        step_cycle(1, 4'h1, 2'b11);
        chk("lda_resume_cw", 32'(s_cw), 32'(M_RAM_OUT | M_ACC_IN));
        step_cycle(1, 4'hF, 2'b11);
        chk("lda_done", 32'(s_t), 32'd1);
        chk("stall_flags_held", 32'(s_flags), 32'd2);

        // HLT, then undefined 1011 after reset
        step_cycle(1, 4'hF, 2'b11);
        step_cycle(1, 4'hF, 2'b11);
        chk("hlt_t3_cw", 32'(s_cw), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step_cycle(1, 4'hF, 2'b11);
            chk("hlt_halted", 32'(s_halted), 32'd1);
            chk("hlt_t3_stuck", 32'(s_t), 32'd3);
        end
        apply_reset();
        step_cycle(1, 4'hB, 2'b11);
        step_cycle(1, 4'hB, 2'b11);
        step_cycle(1, 4'hB, 2'b11);
        chk("undef_t3_cw", 32'(s_cw), 32'd0);
        step_cycle(1, 4'hB, 2'b11);
        chk("undef_3cycles", 32'(s_t), 32'd1);
        step_cycle(1, 4'h0, 2'b11);

        // Randomized instruction stream against the reference model
        for (int n = 0; n < 250; n++) begin
            r_op = 4'($urandom_range(0, 15));
            if (r_op == 4'hF && $urandom_range(0, 3) != 0) r_op = 4'h0;
            guard = 0;
            moved = 1'b0;
            do begin
                r_en = ($urandom_range(0, 3) != 0);
                step_cycle(r_en, r_op, 2'($urandom));
                if (m_t != 1) moved = 1'b1;
                guard++;
            end while (!m_halted && (m_t != 1 || !moved) && guard < 60);
            if (guard >= 60) begin
                chk("rand_instr_bound", 32'(guard), 32'd0);
            end
            if (m_halted) begin
                step_cycle(1, 4'($urandom), 2'($urandom));
                step_cycle(0, 4'($urandom), 2'($urandom));
                apply_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
